// File: rtl/phy_rx_sp_lane_pkg.sv
// Shared PHY constants: the alignment symbol, the lock depth and the receive-lane state encoding.
package phy_rx_sp_lane_pkg;

  localparam int unsigned SYM_W              = 8;
  localparam logic [7:0]  COM_SYM            = 8'hBC;
  localparam int unsigned LOCK_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    SYNC   = 2'b01,
    ACTIVE = 2'b10
  } lane_state_e;

  typedef struct packed {
    logic [SYM_W-1:0] data;
    logic             strobe;
    logic             valid;
    logic             active;
  } lane_out_t;

endpackage

// File: rtl/phy_rx_sp_lane_if.sv
// Lane-side signal bundle: the serial bit in, the deserialised byte and its qualifiers out.
interface phy_rx_sp_lane_if;
  import phy_rx_sp_lane_pkg::*;

  logic             data_in;
  logic [SYM_W-1:0] data_out;
  logic             byte_strobe;
  logic             valid_out;
  logic             active;

  modport master (
    output data_in,
    input  data_out,
    input  byte_strobe,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output byte_strobe,
    output valid_out,
    output active
  );

endinterface

// File: rtl/sp_shift8.sv
// MSB-first serial shift register; window is the last 8 bits including the bit currently on din.
module sp_shift8
  import phy_rx_sp_lane_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [SYM_W-1:0] window
);

  logic [SYM_W-1:0] sr_q;

  assign window = {sr_q[SYM_W-2:0], din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= window;
    end
  end

endmodule

// File: rtl/phy_rx_sp_lane.sv
// Per-lane serial-to-parallel receiver: COM-based byte alignment, lock qualification and byte strobing.
module phy_rx_sp_lane
  import phy_rx_sp_lane_pkg::*;
#(
  parameter logic [7:0]  COM_SYM    = phy_rx_sp_lane_pkg::COM_SYM,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  phy_rx_sp_lane_if.slave  lane
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  lane_state_e      state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       com_cnt_q, com_cnt_d;
  logic [3:0]       com_inc;
  logic [SYM_W-1:0] window;
  logic             is_com;
  logic             byte_done;
  lane_out_t        out_q, out_d;

  sp_shift8 u_shift (
    .clk    (clk_32f),
    .rst_n  (reset_L),
    .din    (lane.data_in),
    .window (window)
  );

  assign is_com    = (window == COM_SYM);
  assign byte_done = (state_q != SEARCH) && (bit_cnt_q == 3'd7);
  // Saturating increment keeps com_cnt from ever wrapping past LOCK_COUNT.
  assign com_inc   = (com_cnt_q == LOCK_N) ? com_cnt_q : com_cnt_q + 4'd1;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    case (state_q)
      SEARCH: begin
        if (is_com) begin
          bit_cnt_d = '0;
          com_cnt_d = 4'd1;
          if (LOCK_N == 4'd1) begin
            state_d = ACTIVE;
          end else begin
            state_d = SYNC;
          end
        end
      end
      SYNC: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (is_com) begin
            com_cnt_d = com_inc;
            if (com_inc == LOCK_N) begin
              state_d = ACTIVE;
            end
          end else begin
            // Alignment lost: fall back without re-testing this edge's window.
            state_d   = SEARCH;
            bit_cnt_d = '0;
            com_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      default: begin
        state_d   = SEARCH;
        bit_cnt_d = '0;
        com_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    out_d        = out_q;
    out_d.strobe = 1'b0;
    out_d.active = (state_d == ACTIVE);
    if ((state_q == ACTIVE) && byte_done) begin
      out_d.data   = window;
      out_d.strobe = 1'b1;
      out_d.valid  = !is_com;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign lane.data_out    = out_q.data;
  assign lane.byte_strobe = out_q.strobe;
  assign lane.valid_out   = out_q.valid;
  assign lane.active      = out_q.active;

  a_strobe_spaced: assert property (@(posedge clk_32f) disable iff (!reset_L)
    out_q.strobe |=> !out_q.strobe);

  a_com_cnt_bound: assert property (@(posedge clk_32f) disable iff (!reset_L)
    com_cnt_q <= LOCK_N);

endmodule

// File: tb/tb_phy_rx_sp_lane.sv
// Scoreboard bench for phy_rx_sp_lane: bit-level driver with reference model, negedge monitor.
module tb_phy_rx_sp_lane;
  import phy_rx_sp_lane_pkg::*;

  localparam int unsigned LOCK = 4;
  localparam logic [7:0]  COM  = 8'hBC;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;

  phy_rx_sp_lane_if lane ();

  phy_rx_sp_lane #(.COM_SYM(COM), .LOCK_COUNT(LOCK)) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .lane    (lane)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    int         tag;
    logic [7:0] data;
    logic       valid;
  } exp_t;

  exp_t sq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_idx = 0;

  // Reference model state: recent bits, candidate alignment anchor, COM tally, lock point.
  logic [7:0] m_win      = '0;
  bit         m_track    = 1'b0;
  bit         m_locked   = 1'b0;
  int         m_anchor   = 0;
  int         m_ncom     = 0;
  int         m_lock_edge = 0;
  int         m_lock_tag  = 0;

  logic [7:0] hold_d    = '0;
  logic       hold_v    = 1'b0;
  int         rise_idx  = -1;
  bit         seen_rise = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", name, act, exp, edge_idx, $time);
    end
  endfunction

  // k is the 0-based index of the edge that samples bit b; outputs from it appear once edge_idx == k+1.
  function automatic void model_bit(input logic b, input int k);
    exp_t e;
    m_win = {m_win[6:0], b};
    if (m_locked) begin
      if (k > m_lock_edge && ((k - m_lock_edge) % 8) == 0) begin
        e.tag   = k + 1;
        e.data  = m_win;
        e.valid = (m_win != COM);
        sq.push_back(e);
      end
    end else if (m_track) begin
      if (((k - m_anchor) % 8) == 0) begin
        if (m_win == COM) begin
          m_ncom++;
          if (m_ncom == int'(LOCK)) begin
            m_locked    = 1'b1;
            m_lock_edge = k;
            m_lock_tag  = k + 1;
          end
        end else begin
          m_track = 1'b0;
        end
      end
    end else if (m_win == COM) begin
      m_track  = 1'b1;
      m_anchor = k;
      m_ncom   = 1;
      if (m_ncom == int'(LOCK)) begin
        m_locked    = 1'b1;
        m_lock_edge = k;
        m_lock_tag  = k + 1;
      end
    end
  endfunction

  task automatic drive_bit(input logic b);
    lane.data_in = b;
    model_bit(b, edge_idx);
    @(posedge clk_32f);
    edge_idx++;
    @(negedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic do_reset(input int pre);
    check("queue_drained", sq.size(), 0);
    #(pre);
    reset_L = 1'b0;
    #1;
    check("rst_data_out", int'(lane.data_out), 0);
    check("rst_strobe", int'(lane.byte_strobe), 0);
    check("rst_valid", int'(lane.valid_out), 0);
    check("rst_active", int'(lane.active), 0);
    sq.delete();
    m_win = '0; m_track = 1'b0; m_locked = 1'b0;
    m_anchor = 0; m_ncom = 0; m_lock_edge = 0; m_lock_tag = 0;
    hold_d = '0; hold_v = 1'b0; rise_idx = -1; seen_rise = 1'b0;
    edge_idx = 0;
    repeat (2) @(posedge clk_32f);
    @(negedge clk_32f);
    #1;
    reset_L = 1'b1;
  endtask

  always @(negedge clk_32f) begin
    exp_t e;
    check("active", int'(lane.active), int'(m_locked && edge_idx >= m_lock_tag));
    if (lane.active && !seen_rise) begin
      seen_rise = 1'b1;
      rise_idx  = edge_idx;
    end
    if (lane.byte_strobe) begin
      if (sq.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sq.pop_front();
        check("strobe_edge", edge_idx, e.tag);
        check("data_out", int'(lane.data_out), int'(e.data));
        check("valid_out", int'(lane.valid_out), int'(e.valid));
        hold_d = e.data;
        hold_v = e.valid;
      end
    end else begin
      if (sq.size() > 0 && sq[0].tag <= edge_idx) begin
        e = sq.pop_front();
        check("missing_strobe", 0, 1);
      end
      check("data_hold", int'(lane.data_out), int'(hold_d));
      check("valid_hold", int'(lane.valid_out), int'(hold_v));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned p;
    int unsigned n;
    lane.data_in = 1'b0;
    do_reset(0);

    // Aligned COM stream from reset, then data bytes.
    repeat (4) send_byte(COM);
    check("align_rise", rise_idx, 32);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(COM);
    repeat (5) drive_bit(1'b0);
    do_reset(0);

    // Misaligned start.
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    repeat (4) send_byte(COM);
    send_byte(8'h5A);
    check("misalign_rise", rise_idx, 35);
    do_reset(0);

    // Broken sync.
    send_byte(COM); send_byte(COM); send_byte(8'h12);
    repeat (4) send_byte(COM);
    send_byte(8'h00);
    check("broken_rise", rise_idx, 56);
    do_reset(0);

    // Spurious COM straddling two data bytes.
    send_byte(8'h5E); send_byte(8'h40);
    repeat (4) send_byte(COM);
    send_byte(8'h99);
    check("spurious_rise", rise_idx, 48);
    do_reset(0);

    // Reset while ACTIVE, part-way through a byte.
    repeat (4) send_byte(COM);
    send_byte(8'h81);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
    do_reset(2);
    repeat (3) send_byte(COM);
    send_byte(8'hA5);
    repeat (4) send_byte(COM);
    send_byte(8'h77);
    check("relock_rise", rise_idx, 64);
    do_reset(0);

    // Randomised slips, broken COM runs and mixed data.
    for (int t = 0; t < 30; t++) begin
      p = $urandom_range(0, 7);
      n = $urandom_range(2, 6);
      for (int i = 0; i < int'(p); i++) drive_bit(1'($urandom_range(0, 1)));
      for (int i = 0; i < int'(n); i++) begin
        if ($urandom_range(0, 5) == 0) send_byte(8'($urandom));
        else send_byte(COM);
      end
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 3) == 0) send_byte(COM);
        else send_byte(8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) do_reset(2);
      else do_reset(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
